// File: rtl/ps2_rx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ps2_rx_fifo
// Purpose  : PS/2 device-to-host receiver with a small byte FIFO. The raw
//            ps2_clock/ps2_data pins are synchronised into the system clock
//            domain, 11-bit frames (start, 8 data LSB first, odd parity,
//            stop) are deserialised, and valid scan-code bytes are queued
//            for the processor, which pops them one byte per ps2_read cycle.
// Ports    : clock           - system clock, rising edge
//            reset           - synchronous, active-high
//            ps2_clock       - raw PS/2 clock pin (asynchronous)
//            ps2_data        - raw PS/2 data pin (asynchronous)
//            ps2_read        - pop strobe, one byte per cycle high
//            ps2_key_pressed - FIFO not empty
//            ps2_out         - FIFO head byte, 8'h00 when empty
//            parity_error    - one-cycle pulse on a parity failure
//            frame_error     - one-cycle pulse on bad stop bit or timeout
//            overflow        - sticky, a valid byte was dropped (FIFO full)
// Options  : PS2_BREAK_FILTER_EN - when defined, an F0 break prefix and the
//            byte following it are swallowed instead of queued.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_rx_fifo #(
  parameter int DEPTH          = 8,
  parameter int ADDR_W         = 3,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clock,
  input  logic       ps2_data,
  input  logic       ps2_read,
  output logic       ps2_key_pressed,
  output logic [7:0] ps2_out,
  output logic       parity_error,
  output logic       frame_error,
  output logic       overflow
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  localparam logic [ADDR_W-1:0] PTR_ONE   = 1;
  localparam logic [ADDR_W:0]   CNT_ONE   = 1;
  localparam logic [ADDR_W:0]   CNT_FULL  = DEPTH[ADDR_W:0];
  localparam logic [TMR_W-1:0]  TMR_ONE   = 1;
  localparam logic [TMR_W-1:0]  TMR_LIMIT = TIMEOUT_CYCLES[TMR_W-1:0];
  localparam logic [7:0]        BREAK_CODE = 8'hF0;

  // --------------------------------------------------------------------------
  // Input synchronisers; idle bus level is high, so they reset to 1.
  // --------------------------------------------------------------------------
  logic clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d, clk_prev_q, clk_prev_d;
  logic dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic fall;
  logic bit_in;

  always_comb begin
    clk_s1_d   = ps2_clock;
    clk_s2_d   = clk_s1_q;
    clk_prev_d = clk_s2_q;
    dat_s1_d   = ps2_data;
    dat_s2_d   = dat_s1_q;
  end

  assign fall   = clk_prev_q & ~clk_s2_q;
  assign bit_in = dat_s2_q;

  // --------------------------------------------------------------------------
  // Receive FSM: state register / next-state logic / output logic
  // --------------------------------------------------------------------------
  logic [1:0]       state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             timeout;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Timeout is only checked on cycles without an edge, since an edge restarts
  // the inter-bit interval.
  assign timeout = (state_q != ST_IDLE) && !fall && (timer_q == TMR_LIMIT);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    if (timeout) begin
      state_d = ST_IDLE;
    end else if (fall) begin
      case (state_q)
        ST_IDLE: begin
          if (!bit_in) begin
            state_d   = ST_DATA;
            bit_cnt_d = 3'd0;
          end
        end
        ST_DATA: begin
          shift_d = {bit_in, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        ST_PARITY: begin
          parity_d = bit_in;
          state_d  = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    if ((state_q == ST_IDLE) || fall || timeout) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TMR_ONE;
    end
  end

  logic stop_edge, odd_ok;
  logic frame_err_d, parity_err_d, byte_ok;

  // Stop bit low wins over a parity failure.
  always_comb begin
    stop_edge    = fall && (state_q == ST_STOP);
    odd_ok       = ^{shift_q, parity_q};
    frame_err_d  = timeout | (stop_edge & ~bit_in);
    parity_err_d = stop_edge & bit_in & ~odd_ok;
    byte_ok      = stop_edge & bit_in & odd_ok;
  end

  // --------------------------------------------------------------------------
  // Optional break-code filter
  // --------------------------------------------------------------------------
  logic push_req;

`ifdef PS2_BREAK_FILTER_EN
  logic skip_q, skip_d;

  always_comb begin
    skip_d   = skip_q;
    push_req = 1'b0;
    if (byte_ok) begin
      if (skip_q) begin
        skip_d = 1'b0;
      end else if (shift_q == BREAK_CODE) begin
        skip_d = 1'b1;
      end else begin
        push_req = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      skip_q <= 1'b0;
    end else begin
      skip_q <= skip_d;
    end
  end
`else
  localparam logic [7:0] UNUSED_BREAK = BREAK_CODE;
  always_comb begin
    push_req = byte_ok | (UNUSED_BREAK != UNUSED_BREAK);
  end
`endif

  // --------------------------------------------------------------------------
  // Byte FIFO
  // --------------------------------------------------------------------------
  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              parity_err_q, frame_err_q;
  logic              pop, full, wr_en;

  always_comb begin
    pop        = ps2_read && (count_q != '0);
    full       = (count_q == CNT_FULL);
    // A full FIFO still accepts the byte when a pop frees a slot this cycle.
    wr_en      = push_req && (!full || pop);
    overflow_d = overflow_q | (push_req & full & ~pop);
    wr_ptr_d   = wr_en ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d   = pop   ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      clk_s1_q     <= 1'b1;
      clk_s2_q     <= 1'b1;
      clk_prev_q   <= 1'b1;
      dat_s1_q     <= 1'b1;
      dat_s2_q     <= 1'b1;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      parity_q     <= 1'b0;
      timer_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      clk_s1_q     <= clk_s1_d;
      clk_s2_q     <= clk_s2_d;
      clk_prev_q   <= clk_prev_d;
      dat_s1_q     <= dat_s1_d;
      dat_s2_q     <= dat_s2_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      timer_q      <= timer_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Outputs come only from registered state; ps2_read has no path to them.
  assign ps2_key_pressed = (count_q != '0);
  assign ps2_out         = (count_q != '0) ? mem_q[rd_ptr_q] : 8'h00;
  assign parity_error    = parity_err_q;
  assign frame_error     = frame_err_q;
  assign overflow        = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ps2_rx_fifo
// Purpose  : Directed self-checking bench for ps2_rx_fifo. Expected bytes are
//            queued in a scoreboard as frames are sent and compared as the
//            processor side pops them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_rx_fifo;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clock = 1'b1;
  logic       ps2_data = 1'b1;
  logic       ps2_read = 1'b0;
  logic       ps2_key_pressed;
  logic [7:0] ps2_out;
  logic       parity_error;
  logic       frame_error;
  logic       overflow;

  int n_cmp  = 0;
  int n_fail = 0;
  int pe_cnt = 0;
  int fe_cnt = 0;
  logic [7:0] sb[$];

  ps2_rx_fifo #(
    .DEPTH(8),
    .ADDR_W(3),
    .TIMEOUT_CYCLES(10000)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .ps2_clock      (ps2_clock),
    .ps2_data       (ps2_data),
    .ps2_read       (ps2_read),
    .ps2_key_pressed(ps2_key_pressed),
    .ps2_out        (ps2_out),
    .parity_error   (parity_error),
    .frame_error    (frame_error),
    .overflow       (overflow)
  );

  always #5 clock = ~clock;

  // A one-cycle pulse is seen at exactly one falling clock edge.
  always @(negedge clock) begin
    if (parity_error === 1'b1) pe_cnt <= pe_cnt + 1;
    if (frame_error === 1'b1)  fe_cnt <= fe_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Drives start, data, parity and stop; returns just after the 11th falling
  // edge with ps2_clock still low.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp, input int half);
    logic [10:0] bits;
    bits = {stp, par, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ps2_data = bits[i];
      tick(half);
      ps2_clock = 1'b0;
      if (i != 10) begin
        tick(half);
        ps2_clock = 1'b1;
      end
    end
  endtask

  task automatic finish_frame(input int half);
    tick(half);
    ps2_clock = 1'b1;
    ps2_data  = 1'b1;
    tick(half);
  endtask

  task automatic send_byte(input logic [7:0] d, input int half);
    send_frame(d, ~^d, 1'b1, half);
    finish_frame(half);
  endtask

  // Start bit plus nbits data bits, bus left with ps2_clock high.
  task automatic send_partial(input logic [7:0] d, input int nbits, input int half);
    logic [8:0] bits;
    bits = {d, 1'b0};
    for (int i = 0; i <= nbits; i++) begin
      ps2_data = bits[i];
      tick(half);
      ps2_clock = 1'b0;
      tick(half);
      ps2_clock = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic read_check(input string tag);
    logic [7:0] exp;
    @(negedge clock);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      exp = sb.pop_front();
      check({tag, "_key"}, {31'd0, ps2_key_pressed}, 32'd1);
      check({tag, "_out"}, {24'd0, ps2_out}, {24'd0, exp});
    end
    @(posedge clock); #1 ps2_read = 1'b1;
    @(posedge clock); #1 ps2_read = 1'b0;
  endtask

  task automatic check_empty(input string tag);
    @(negedge clock);
    check({tag, "_key"}, {31'd0, ps2_key_pressed}, 32'd0);
    check({tag, "_out"}, {24'd0, ps2_out}, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ps2_clock = 1'b1;
    ps2_data  = 1'b1;
    ps2_read  = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(2);
    sb.delete();
  endtask

  initial begin
    int pe0, fe0;
    localparam int H = 20;

    // ---- reset state
    tick(3);
    @(negedge clock);
    check("rst_key", {31'd0, ps2_key_pressed}, 32'd0);
    check("rst_out", {24'd0, ps2_out}, 32'd0);
    check("rst_pe",  {31'd0, parity_error}, 32'd0);
    check("rst_fe",  {31'd0, frame_error}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    do_reset();

    // ---- valid 1C frame, 2000-clock bit period, latency bound
    sb.push_back(8'h1C);
    send_frame(8'h1C, 1'b0, 1'b1, 1000);
    repeat (4) @(posedge clock);
    #1;
    check("lat_key", {31'd0, ps2_key_pressed}, 32'd1);
    check("lat_out", {24'd0, ps2_out}, {24'd0, sb[0]});
    finish_frame(1000);
    read_check("v1c");
    check_empty("v1c_after_pop");
    // pop while empty is ignored
    ps2_read = 1'b1; tick(1); ps2_read = 1'b0;
    check_empty("empty_pop");

    // ---- parity error, then stop-bit error
    pe0 = pe_cnt; fe0 = fe_cnt;
    send_frame(8'h1C, 1'b1, 1'b1, H);
    finish_frame(H);
    tick(10);
    check("par_pe", pe_cnt - pe0, 1);
    check("par_fe", fe_cnt - fe0, 0);
    check_empty("par_empty");
    pe0 = pe_cnt; fe0 = fe_cnt;
    send_frame(8'h1C, 1'b0, 1'b0, H);
    finish_frame(H);
    tick(10);
    check("stop_fe", fe_cnt - fe0, 1);
    check("stop_pe", pe_cnt - pe0, 0);
    check_empty("stop_empty");

    // ---- timeout mid-frame, then recovery
    pe0 = pe_cnt; fe0 = fe_cnt;
    send_partial(8'h55, 3, H);
    tick(10001);
    tick(10);
    check("tmo_fe", fe_cnt - fe0, 1);
    check("tmo_pe", pe_cnt - pe0, 0);
    check_empty("tmo_empty");
    sb.push_back(8'h29);
    send_byte(8'h29, H);
    read_check("tmo_29");
    check_empty("tmo_only29");

    // ---- reset mid-frame with a byte already queued
    send_byte(8'h44, H);
    send_partial(8'hA5, 4, H);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    sb.delete();
    @(negedge clock);
    check("mrst_key", {31'd0, ps2_key_pressed}, 32'd0);
    check("mrst_out", {24'd0, ps2_out}, 32'd0);
    check("mrst_pe",  {31'd0, parity_error}, 32'd0);
    check("mrst_fe",  {31'd0, frame_error}, 32'd0);
    check("mrst_ovf", {31'd0, overflow}, 32'd0);
    sb.push_back(8'h3A);
    send_byte(8'h3A, H);
    read_check("mrst_3a");
    check_empty("mrst_empty");

    // ---- full FIFO, pop in the same cycle the 5A push lands
    do_reset();
    for (int k = 0; k < 8; k++) begin
      sb.push_back(8'h10 + 8'(k));
      send_byte(8'h10 + 8'(k), H);
    end
    send_frame(8'h5A, ~^8'h5A, 1'b1, H);
    // The byte commits three clocks after the pin edge; hold ps2_read across
    // exactly that clock edge.
    tick(2);
    ps2_read = 1'b1;
    @(negedge clock);
    check("pp_head", {24'd0, ps2_out}, {24'd0, sb.pop_front()});
    tick(1);
    ps2_read = 1'b0;
    sb.push_back(8'h5A);
    finish_frame(H);
    check("pp_ovf", {31'd0, overflow}, 32'd0);
    for (int k = 0; k < 8; k++) read_check("pp_rd");
    check_empty("pp_empty");

    // ---- overflow
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      if (k <= 8) sb.push_back(8'(k));
      send_byte(8'(k), H);
      tick(5);
      if (k == 8) check("ovf_at8", {31'd0, overflow}, 32'd0);
    end
    check("ovf_at9", {31'd0, overflow}, 32'd1);
    for (int k = 0; k < 8; k++) read_check("ovf_rd");
    check_empty("ovf_empty");
    check("ovf_sticky", {31'd0, overflow}, 32'd1);

    // ---- break filter
    do_reset();
`ifdef PS2_BREAK_FILTER_EN
    sb.push_back(8'h32);
`else
    sb.push_back(8'hF0);
    sb.push_back(8'h1C);
    sb.push_back(8'h32);
`endif
    send_byte(8'hF0, H);
    send_byte(8'h1C, H);
    send_byte(8'h32, H);
    while (sb.size() != 0) read_check("brk_rd");
    check_empty("brk_empty");
    check("brk_ovf", {31'd0, overflow}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
